// File: rtl/wt_cache_pkg.sv
// rtl/wt_cache_pkg.sv - shared constants for the write-through cache subsystem
package wt_cache_pkg;
    localparam logic SRC_ICACHE = 1'b0;
    localparam logic SRC_DCACHE = 1'b1;
    // Matches the D$ write-buffer transaction count.
    localparam int unsigned WT_NUM_TX = 8;
endpackage

// File: rtl/wt_tid_table.sv
// rtl/wt_tid_table.sv - per-transaction-ID busy/owner tracking for the memory arbiter
module wt_tid_table
    import wt_cache_pkg::*;
#(
    parameter int unsigned NumTx = WT_NUM_TX,
    parameter int unsigned TidW  = $clog2(NumTx)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             set_i,
    input  logic [TidW-1:0]  set_tid_i,
    input  logic             set_owner_i,
    input  logic             clr_i,
    input  logic [TidW-1:0]  clr_tid_i,
    output logic [NumTx-1:0] busy_o,
    output logic [NumTx-1:0] owner_o,
    output logic             any_busy_o
);

    logic [NumTx-1:0] busy_d, busy_q;
    logic [NumTx-1:0] owner_d, owner_q;

    // A set only hits an idle TID and a clear only a busy one, so they never collide.
    always_comb begin
        busy_d  = busy_q;
        owner_d = owner_q;
        if (clr_i) begin
            busy_d[clr_tid_i] = 1'b0;
        end
        if (set_i) begin
            busy_d[set_tid_i]  = 1'b1;
            owner_d[set_tid_i] = set_owner_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q  <= '0;
            owner_q <= '0;
        end else begin
            busy_q  <= busy_d;
            owner_q <= owner_d;
        end
    end

    assign busy_o     = busy_q;
    assign owner_o    = owner_q;
    assign any_busy_o = |busy_q;

endmodule

// File: rtl/wt_mem_arbiter.sv
// rtl/wt_mem_arbiter.sv - round-robin merge of I$/D$ requests with TID-based return routing
module wt_mem_arbiter
    import wt_cache_pkg::*;
#(
    parameter int unsigned NumTx     = WT_NUM_TX,
    parameter int unsigned ReqWidth  = 128,
    parameter int unsigned RtrnWidth = 256,
    parameter int unsigned TidW      = $clog2(NumTx)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 icache_data_req_i,
    output logic                 icache_data_ack_o,
    input  logic [ReqWidth-1:0]  icache_data_i,
    input  logic [TidW-1:0]      icache_tid_i,
    input  logic                 dcache_data_req_i,
    output logic                 dcache_data_ack_o,
    input  logic [ReqWidth-1:0]  dcache_data_i,
    input  logic [TidW-1:0]      dcache_tid_i,
    output logic                 mem_req_valid_o,
    input  logic                 mem_req_ready_i,
    output logic [ReqWidth-1:0]  mem_req_o,
    output logic [TidW-1:0]      mem_req_tid_o,
    output logic                 mem_req_src_o,
    input  logic                 mem_rtrn_vld_i,
    input  logic [RtrnWidth-1:0] mem_rtrn_i,
    input  logic [TidW-1:0]      mem_rtrn_tid_i,
    output logic                 icache_rtrn_vld_o,
    output logic                 dcache_rtrn_vld_o,
    output logic [RtrnWidth-1:0] rtrn_o,
    output logic                 rtrn_err_o,
    output logic                 busy_o
);

    logic [NumTx-1:0]    tid_busy, tid_owner;
    logic                any_busy;
    logic                elig_i, elig_d, can_load, grant, win_src, hit;
    logic                rr_d, rr_q;
    logic                req_valid_d, req_valid_q;
    logic                req_src_d, req_src_q;
    logic [TidW-1:0]     req_tid_d, req_tid_q;
    logic [ReqWidth-1:0] req_data_d, req_data_q;

    wt_tid_table #(
        .NumTx (NumTx),
        .TidW  (TidW)
    ) u_tid_table (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .set_i       (grant),
        .set_tid_i   (req_tid_d),
        .set_owner_i (win_src),
        .clr_i       (hit),
        .clr_tid_i   (mem_rtrn_tid_i),
        .busy_o      (tid_busy),
        .owner_o     (tid_owner),
        .any_busy_o  (any_busy)
    );

    // Eligibility uses registered busy, so a TID freed this cycle is reusable next cycle.
    always_comb begin
        elig_i   = icache_data_req_i & ~tid_busy[icache_tid_i];
        elig_d   = dcache_data_req_i & ~tid_busy[dcache_tid_i];
        can_load = ~req_valid_q | mem_req_ready_i;
        win_src  = SRC_ICACHE;
        if (elig_i && elig_d) begin
            win_src = rr_q;
        end else if (elig_d) begin
            win_src = SRC_DCACHE;
        end
        grant             = can_load & (elig_i | elig_d);
        icache_data_ack_o = grant & (win_src == SRC_ICACHE);
        dcache_data_ack_o = grant & (win_src == SRC_DCACHE);

        rr_d        = rr_q;
        req_valid_d = req_valid_q;
        req_src_d   = req_src_q;
        req_tid_d   = req_tid_q;
        req_data_d  = req_data_q;
        if (grant) begin
            rr_d        = ~win_src;
            req_valid_d = 1'b1;
            req_src_d   = win_src;
            req_tid_d   = (win_src == SRC_DCACHE) ? dcache_tid_i : icache_tid_i;
            req_data_d  = (win_src == SRC_DCACHE) ? dcache_data_i : icache_data_i;
        end else if (mem_req_ready_i) begin
            req_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q        <= SRC_ICACHE;
            req_valid_q <= 1'b0;
            req_src_q   <= 1'b0;
            req_tid_q   <= '0;
            req_data_q  <= '0;
        end else begin
            rr_q        <= rr_d;
            req_valid_q <= req_valid_d;
            req_src_q   <= req_src_d;
            req_tid_q   <= req_tid_d;
            req_data_q  <= req_data_d;
        end
    end

    always_comb begin
        hit               = mem_rtrn_vld_i & tid_busy[mem_rtrn_tid_i];
        icache_rtrn_vld_o = hit & (tid_owner[mem_rtrn_tid_i] == SRC_ICACHE);
        dcache_rtrn_vld_o = hit & (tid_owner[mem_rtrn_tid_i] == SRC_DCACHE);
        rtrn_err_o        = mem_rtrn_vld_i & ~tid_busy[mem_rtrn_tid_i];
    end

    assign rtrn_o          = mem_rtrn_i;
    assign mem_req_valid_o = req_valid_q;
    assign mem_req_o       = req_data_q;
    assign mem_req_tid_o   = req_tid_q;
    assign mem_req_src_o   = req_src_q;
    assign busy_o          = any_busy | req_valid_q;

endmodule

// File: tb/tb_wt_mem_arbiter.sv
// tb/tb_wt_mem_arbiter.sv - directed self-checking bench for wt_mem_arbiter
module tb_wt_mem_arbiter;

    localparam int NTX  = 8;
    localparam int RQW  = 128;
    localparam int RTW  = 256;
    localparam int TIDW = 3;

    logic            clk, rst_n;
    logic            ireq, iack, dreq, dack;
    logic [RQW-1:0]  idata, ddata, mreq;
    logic [TIDW-1:0] itid, dtid, mtid, rtid;
    logic            mvalid, mready, msrc;
    logic            rv, ivld, dvld, rerr, busy;
    logic [RTW-1:0]  rdata, rout;

    int checks = 0;
    int errors = 0;

    wt_mem_arbiter #(
        .NumTx     (NTX),
        .ReqWidth  (RQW),
        .RtrnWidth (RTW)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .icache_data_req_i (ireq),
        .icache_data_ack_o (iack),
        .icache_data_i     (idata),
        .icache_tid_i      (itid),
        .dcache_data_req_i (dreq),
        .dcache_data_ack_o (dack),
        .dcache_data_i     (ddata),
        .dcache_tid_i      (dtid),
        .mem_req_valid_o   (mvalid),
        .mem_req_ready_i   (mready),
        .mem_req_o         (mreq),
        .mem_req_tid_o     (mtid),
        .mem_req_src_o     (msrc),
        .mem_rtrn_vld_i    (rv),
        .mem_rtrn_i        (rdata),
        .mem_rtrn_tid_i    (rtid),
        .icache_rtrn_vld_o (ivld),
        .dcache_rtrn_vld_o (dvld),
        .rtrn_o            (rout),
        .rtrn_err_o        (rerr),
        .busy_o            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic exp_src [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [TIDW-1:0] exp_tid [4] = '{3'd1, 3'd4, 3'd2, 3'd5};

    initial begin
        rst_n = 1'b0; ireq = 0; dreq = 0; idata = '0; ddata = '0; itid = '0; dtid = '0;
        mready = 0; rv = 0; rdata = '0; rtid = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_iack", iack, 0);
        check_eq("rst_dack", dack, 0);
        check_eq("rst_valid", mvalid, 0);
        check_eq("rst_data", mreq, 0);
        check_eq("rst_tid", mtid, 0);
        check_eq("rst_src", msrc, 0);
        check_eq("rst_rvld", {ivld, dvld, rerr}, 0);
        check_eq("rst_busy", busy, 0);
        rst_n = 1'b1;
        step();

        // single I$ request, tid 0
        ireq = 1; itid = 0; idata = 128'hA1; mready = 1;
        #4;
        check_eq("t1_iack", iack, 1);
        check_eq("t1_dack", dack, 0);
        check_eq("t1_valid_pre", mvalid, 0);
        step();
        ireq = 0;
        #4;
        check_eq("t1_valid", mvalid, 1);
        check_eq("t1_tid", mtid, 0);
        check_eq("t1_src", msrc, 0);
        check_eq("t1_data", mreq, 128'hA1);
        check_eq("t1_busy", busy, 1);
        check_eq("t1_iack_once", iack, 0);
        step();
        rv = 1; rtid = 0; rdata = 256'hBEEF_0001;
        #4;
        check_eq("t1_ivld", ivld, 1);
        check_eq("t1_dvld", dvld, 0);
        check_eq("t1_err", rerr, 0);
        check_eq("t1_rtrn", rout, 256'hBEEF_0001);
        check_eq("t1_busy_ret", busy, 1);
        check_eq("t1_valid_drained", mvalid, 0);
        step();
        rv = 0;
        #4;
        check_eq("t1_busy_fall", busy, 0);

        // alternation from a fresh reset
        rst_n = 0;
        step();
        rst_n = 1;
        step();
        ireq = 1; dreq = 1; itid = 1; dtid = 4;
        for (int k = 0; k < 4; k++) begin
            idata = 128'h100 + itid;
            ddata = 128'h200 + dtid;
            #4;
            check_eq($sformatf("t2_iack%0d", k), iack, !exp_src[k]);
            check_eq($sformatf("t2_dack%0d", k), dack, exp_src[k]);
            if (k > 0) begin
                check_eq($sformatf("t2_src%0d", k - 1), msrc, exp_src[k - 1]);
                check_eq($sformatf("t2_tid%0d", k - 1), mtid, exp_tid[k - 1]);
            end
            step();
            if (exp_src[k]) dtid = dtid + 1;
            else            itid = itid + 1;
        end
        ireq = 0; dreq = 0;
        #4;
        check_eq("t2_src3", msrc, 1);
        check_eq("t2_tid3", mtid, 5);
        check_eq("t2_data3", mreq, 128'h205);
        step();
        step();

        // backpressure with register full
        mready = 0; ireq = 1; itid = 6; idata = 128'hC0DE_0001;
        #4;
        check_eq("t3_iack", iack, 1);
        step();
        ireq = 0; dreq = 1; dtid = 7; ddata = 128'hC0DE_0002;
        for (int k = 0; k < 5; k++) begin
            #4;
            check_eq($sformatf("t3_stall_dack%0d", k), dack, 0);
            check_eq($sformatf("t3_stall_valid%0d", k), mvalid, 1);
            check_eq($sformatf("t3_stall_data%0d", k), mreq, 128'hC0DE_0001);
            step();
        end
        mready = 1;
        #4;
        check_eq("t3_reload_dack", dack, 1);
        check_eq("t3_reload_data_old", mreq, 128'hC0DE_0001);
        step();
        dreq = 0;
        #4;
        check_eq("t3_valid_new", mvalid, 1);
        check_eq("t3_data_new", mreq, 128'hC0DE_0002);
        check_eq("t3_tid_new", mtid, 7);
        check_eq("t3_src_new", msrc, 1);
        step();

        // request on a busy TID waits for its return
        ireq = 1; itid = 3; idata = 128'hD3;
        #4;
        check_eq("t4_iack", iack, 1);
        step();
        ireq = 0; dreq = 1; dtid = 3; ddata = 128'hE3;
        #4;
        check_eq("t4_dack_busy", dack, 0);
        step();
        rv = 1; rtid = 3;
        #4;
        check_eq("t4_dack_same", dack, 0);
        check_eq("t4_ivld", ivld, 1);
        check_eq("t4_dvld", dvld, 0);
        step();
        rv = 0;
        #4;
        check_eq("t4_dack_next", dack, 1);
        step();
        dreq = 0;

        // return on tid 5 (D$ owned), then again while idle
        rv = 1; rtid = 5;
        #4;
        check_eq("t5_dvld", dvld, 1);
        check_eq("t5_ivld", ivld, 0);
        check_eq("t5_err0", rerr, 0);
        step();
        #4;
        check_eq("t5_err", rerr, 1);
        check_eq("t5_vlds_idle", {ivld, dvld}, 0);
        step();
        rv = 0;
        #4;
        check_eq("t5_err_pulse", rerr, 0);
        check_eq("t5_busy", busy, 1);
        step();

        // asynchronous reset with TIDs in flight and the register full
        mready = 0; ireq = 1; itid = 0; idata = 128'hF00D;
        #4;
        check_eq("t6_iack", iack, 1);
        step();
        ireq = 0;
        #4;
        check_eq("t6_valid", mvalid, 1);
        #2;
        rst_n = 0;
        #1;
        check_eq("t6_rst_valid", mvalid, 0);
        check_eq("t6_rst_data", mreq, 0);
        check_eq("t6_rst_tid", mtid, 0);
        check_eq("t6_rst_src", msrc, 0);
        check_eq("t6_rst_busy", busy, 0);
        check_eq("t6_rst_acks", {iack, dack}, 0);
        step();
        rst_n = 1;
        step();
        rv = 1; rtid = 2;
        #4;
        check_eq("t6_err", rerr, 1);
        check_eq("t6_vlds", {ivld, dvld}, 0);
        step();
        rv = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
